// File: rtl/cpu_ctrl_pkg.sv
// Opcode map, sequencer state encoding and instruction-length decode for the 8-bit lab CPU.
// Pure definitions; no latency or flow control of its own.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] RR_USER_IN = 2'd3;

  typedef enum logic [2:0] {
    ST_F0,
    ST_F1,
    ST_O0,
    ST_O1,
    ST_EX,
    ST_HLT
  } state_e;

  function automatic logic two_byte(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for ADD/SUB/AND/OR/XOR/SHL; other opcodes pass acc and carry through.
// Zero latency, no flow control: result is valid in the same cycle as its inputs.
module cpu_alu
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] acc,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] result,
  output logic       c_out,
  output logic       z
);

  always_comb begin
    result = acc;
    c_out  = c_in;
    case (op)
      OP_ADD: {c_out, result} = {1'b0, acc} + {1'b0, b};
      OP_SUB: begin
        result = acc - b;
        c_out  = (acc < b);
      end
      OP_AND: result = acc & b;
      OP_OR:  result = acc | b;
      OP_XOR: result = acc ^ b;
      OP_SHL: begin
        c_out  = acc[7];
        result = {acc[6:0], 1'b0};
      end
      default: ;
    endcase
  end

  assign z = (result == 8'h00);

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer: 3 cycles per 1-byte instruction, 5 per 2-byte.
// No backpressure: ROM and register file are assumed always ready; HALT parks until reset.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] pm_addr,
  input  logic [7:0] pm_data,
  output logic [1:0] rf_a,
  output logic       rf_ce,
  output logic [7:0] rf_wdata,
  input  logic [7:0] rf_rdata,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:2] ir_q, ir_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d;
  logic       c_q, c_d;

  logic [3:0] op;
  logic [1:0] rr;
  logic [7:0] alu_result;
  logic       alu_c;
  logic       alu_z;

  assign op = ir_q[7:4];
  assign rr = ir_q[3:2];

  cpu_alu u_alu (
    .op     (op),
    .acc    (acc_q),
    .b      (rf_rdata),
    .c_in   (c_q),
    .result (alu_result),
    .c_out  (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_F0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      z_q       <= z_d;
      c_q       <= c_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    z_d       = z_q;
    c_d       = c_q;
    rf_a      = 2'd0;
    rf_ce     = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_F0: state_d = ST_F1;
      ST_F1: begin
        ir_d    = pm_data[7:2];
        pc_d    = pc_q + 8'd1;
        state_d = two_byte(pm_data[7:4]) ? ST_O0 : ST_EX;
      end
      ST_O0: state_d = ST_O1;
      ST_O1: begin
        operand_d = pm_data;
        pc_d      = pc_q + 8'd1;
        state_d   = ST_EX;
      end
      ST_EX: begin
        rf_a    = rr;
        state_d = (op == OP_HALT) ? ST_HLT : ST_F0;
        case (op)
          OP_LDI: begin
            acc_d = operand_q;
            z_d   = (operand_q == 8'h00);
          end
          OP_MOV: begin
            acc_d = rf_rdata;
            z_d   = (rf_rdata == 8'h00);
          end
          // user_in is read-only, so a store to it is dropped here
          OP_ST: rf_ce = (rr != RR_USER_IN);
          OP_ADD, OP_SUB, OP_SHL: begin
            acc_d = alu_result;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          OP_AND, OP_OR, OP_XOR: begin
            acc_d = alu_result;
            z_d   = alu_z;
          end
          OP_JMP: pc_d = operand_q;
          OP_JZ:  if (z_q) pc_d = operand_q;
          OP_JC:  if (c_q) pc_d = operand_q;
          default: ;
        endcase
      end
      ST_HLT: halted = 1'b1;
      default: state_d = ST_F0;
    endcase
  end

  assign pm_addr  = pc_q;
  assign rf_wdata = acc_q;
  assign acc      = acc_q;
  assign flag_z   = z_q;
  assign flag_c   = c_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: sync ROM + register-file environment, instruction-level reference model.
module tb_cpu_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic [1:0] rf_a;
  logic       rf_ce;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic       halted;

  cpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pm_addr  (pm_addr),
    .pm_data  (pm_data),
    .rf_a     (rf_a),
    .rf_ce    (rf_ce),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata),
    .acc      (acc),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: synchronous program ROM and the 3-register file plus user_in.
  logic [7:0] rom [0:255];
  logic [7:0] env_init [0:3];
  logic [7:0] env_regs [0:3];
  logic [7:0] user_in;
  int         wr_cnt = 0;

  always @(posedge clk) pm_data <= rom[pm_addr];

  always @(posedge clk) begin
    if (!rst_n) env_regs <= env_init;
    else if (rf_ce) env_regs[rf_a] <= rf_wdata;
  end

  always @(posedge clk) if (rf_ce) wr_cnt <= wr_cnt + 1;

  assign rf_rdata = (rf_a == 2'd3) ? user_in : env_regs[rf_a];

  // Reference model state: architectural view after each whole instruction.
  logic [7:0] m_pc, m_acc;
  logic       m_z, m_c, m_halt;
  logic [7:0] m_regs [0:2];
  int         m_wr;
  int         wr_base;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(output int cyc);
    logic [7:0] ins, imm, r;
    logic [3:0] op;
    logic [1:0] rr;
    int         sum;
    ins  = rom[m_pc];
    m_pc = m_pc + 8'd1;
    op   = ins[7:4];
    rr   = ins[3:2];
    cyc  = 3;
    imm  = 8'h00;
    if (op == 4'h1 || op == 4'hA || op == 4'hB || op == 4'hC) begin
      imm  = rom[m_pc];
      m_pc = m_pc + 8'd1;
      cyc  = 5;
    end
    r = (rr == 2'd3) ? user_in : m_regs[rr];
    case (op)
      4'h1: begin m_acc = imm; m_z = (m_acc == 0); end
      4'h2: begin m_acc = r;   m_z = (m_acc == 0); end
      4'h3: if (rr != 2'd3) begin m_regs[rr] = m_acc; m_wr++; end
      4'h4: begin
        sum   = int'(m_acc) + int'(r);
        m_c   = (sum > 255);
        m_acc = 8'(sum % 256);
        m_z   = (m_acc == 0);
      end
      4'h5: begin m_c = (m_acc < r); m_acc = 8'((int'(m_acc) - int'(r) + 256) % 256); m_z = (m_acc == 0); end
      4'h6: begin m_acc = m_acc & r; m_z = (m_acc == 0); end
      4'h7: begin m_acc = m_acc | r; m_z = (m_acc == 0); end
      4'h8: begin m_acc = m_acc ^ r; m_z = (m_acc == 0); end
      4'h9: begin m_c = (m_acc >= 8'h80); m_acc = 8'((int'(m_acc) * 2) % 256); m_z = (m_acc == 0); end
      4'hA: m_pc = imm;
      4'hB: if (m_z) m_pc = imm;
      4'hC: if (m_c) m_pc = imm;
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_acc"}, acc, m_acc);
    chk({tag, "_z"}, flag_z, m_z);
    chk({tag, "_c"}, flag_c, m_c);
    chk({tag, "_pc"}, pm_addr, m_pc);
    chk({tag, "_halted"}, halted, m_halt);
    chk({tag, "_rf_a"}, rf_a, 2'd0);
    chk({tag, "_rf_ce"}, rf_ce, 1'b0);
    chk({tag, "_wdata"}, rf_wdata, m_acc);
    for (int i = 0; i < 3; i++) chk({tag, "_reg"}, env_regs[i], m_regs[i]);
    chk({tag, "_writes"}, wr_cnt - wr_base, m_wr);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m_pc   = 8'h00;
    m_acc  = 8'h00;
    m_z    = 1'b0;
    m_c    = 1'b0;
    m_halt = 1'b0;
    m_wr   = 0;
    for (int i = 0; i < 3; i++) m_regs[i] = env_init[i];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pm_addr, 8'h00);
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", {flag_z, flag_c}, 2'b00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_rf", {rf_ce, rf_a}, 3'b000);
    wr_base = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int max_instr);
    int cyc;
    for (int n = 0; n < max_instr && !m_halt; n++) begin
      model_step(cyc);
      repeat (cyc) @(posedge clk);
      #1;
      check_all("step");
    end
    if (m_halt) begin
      repeat (4) @(posedge clk);
      #1;
      check_all("hlt");
    end
  endtask

  initial begin
    int base_w;
    rst_n   = 1'b0;
    user_in = 8'h00;
    for (int i = 0; i < 4; i++) env_init[i] = 8'h00;
    clear_rom();

    // LDI then HALT
    rom[0] = 8'h10; rom[1] = 8'h2A; rom[2] = 8'hF0;
    do_reset();
    run(10);
    chk("p1_acc", acc, 8'h2A);
    chk("p1_z", flag_z, 1'b0);
    chk("p1_halted", halted, 1'b1);
    chk("p1_pc", pm_addr, 8'h03);

    // ST r0 then ADD r0 overflowing to zero
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'hFF; rom[2] = 8'h30; rom[3] = 8'h10;
    rom[4] = 8'h01; rom[5] = 8'h40; rom[6] = 8'hF0;
    do_reset();
    run(10);
    chk("p2_acc", acc, 8'h00);
    chk("p2_zc", {flag_z, flag_c}, 2'b11);
    chk("p2_r0", env_regs[0], 8'hFF);
    chk("p2_writes", wr_cnt - wr_base, 1);

    // SUB from user_in with borrow, then ST to user_in is suppressed
    clear_rom();
    user_in = 8'h07;
    rom[0] = 8'h10; rom[1] = 8'h05; rom[2] = 8'h5C; rom[3] = 8'h3C; rom[4] = 8'hF0;
    do_reset();
    run(10);
    chk("p3_acc", acc, 8'hFE);
    chk("p3_zc", {flag_z, flag_c}, 2'b01);
    chk("p3_writes", wr_cnt - wr_base, 0);

    // JZ taken and not taken
    for (int t = 0; t < 2; t++) begin
      clear_rom();
      rom[0] = 8'h10; rom[1] = (t == 0) ? 8'h00 : 8'h01;
      rom[2] = 8'hB0; rom[3] = 8'h08; rom[4] = 8'h10; rom[5] = 8'h11; rom[6] = 8'hF0;
      rom[8] = 8'h10; rom[9] = 8'h22; rom[10] = 8'hF0;
      do_reset();
      run(10);
      chk("p4_acc", acc, (t == 0) ? 8'h22 : 8'h11);
    end

    // JMP whose operand sits at 0xFF
    clear_rom();
    rom[0] = 8'hA0; rom[1] = 8'hFE; rom[8'hFE] = 8'hA0; rom[8'hFF] = 8'h10;
    rom[8'h10] = 8'h10; rom[8'h11] = 8'h5A; rom[8'h12] = 8'hF0;
    do_reset();
    run(10);
    chk("p5_acc", acc, 8'h5A);
    chk("p5_pc", pm_addr, 8'h13);

    // NOP at 0xFF falls through to 0x00
    clear_rom();
    rom[0] = 8'hA0; rom[1] = 8'hFF;
    do_reset();
    run(2);
    chk("p6_wrap", pm_addr, 8'h00);

    // Reset asserted during EX of a store
    clear_rom();
    env_init[0] = 8'h5A;
    rom[0] = 8'h10; rom[1] = 8'hAB; rom[2] = 8'h30; rom[3] = 8'hF0;
    do_reset();
    repeat (7) @(posedge clk);
    #1;
    chk("rst_st_ce", {rf_ce, rf_a}, 3'b100);
    chk("rst_st_wdata", rf_wdata, 8'hAB);
    base_w = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_st_ce_drop", rf_ce, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_st_nowrite", wr_cnt, base_w);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_st_pc", pm_addr, 8'h00);
    chk("rst_st_acc", acc, 8'h00);

    // Random programs, HALT made rare so programs run for a while
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i] = 8'($urandom);
        if (rom[i][7:4] == 4'hF && $urandom_range(0, 9) != 0) rom[i][7:4] = 4'h0;
      end
      for (int i = 0; i < 4; i++) env_init[i] = 8'($urandom);
      user_in = 8'($urandom);
      do_reset();
      run(60);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
